// File: rtl/rr_port_arbiter.sv
// Round-robin merge of NUM_CH valid/ready channels into one FIFO-buffered output stream.
// Each buffered beat carries its source channel index alongside the payload.
module rr_port_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = $clog2(NUM_CH),
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         fill
);

    localparam int PTR_W = CNT_W - 1;

    logic [CH_W+DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_fill;
    logic [CH_W-1:0]        r_last;

    logic [NUM_CH-1:0]      w_req;
    logic                   w_full;
    logic                   w_push;
    logic                   w_pop;
    logic [CH_W-1:0]        w_gidx;

    assign w_req  = in_valid & ch_en;
    assign w_full = (r_fill == CNT_W'(FIFO_DEPTH));

    // Scan starts one past the previous winner and wraps, so the last winner is checked last.
    always_comb begin
        int idx;
        w_push = 1'b0;
        w_gidx = '0;
        idx    = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(r_last) + i) % NUM_CH;
            if (!w_push && !w_full && w_req[idx]) begin
                w_push = 1'b1;
                w_gidx = CH_W'(idx);
            end
        end
    end

    assign in_ready  = w_push ? (NUM_CH'(1) << w_gidx) : '0;
    assign w_pop     = (r_fill != '0) && out_ready;
    assign out_valid = (r_fill != '0);
    assign out_data  = r_mem[r_rptr][DATA_W-1:0];
    assign out_ch    = r_mem[r_rptr][CH_W+DATA_W-1:DATA_W];
    assign fill      = r_fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
            r_last <= CH_W'(NUM_CH - 1);
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {w_gidx, in_data[w_gidx*DATA_W +: DATA_W]};
                r_wptr        <= r_wptr + PTR_W'(1);
                r_last        <= w_gidx;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            // Full gating looks only at registered fill, so fill never exceeds depth.
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + CNT_W'(1);
                2'b01:   r_fill <= r_fill - CNT_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule
